hit_judge: RTL



---
 rtl/ddr_pkg.sv | 31 +++
 rtl/hit_judge_press_detect.sv | 32 +++
 rtl/hit_judge.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ddr_pkg.sv
// Shared lane codes, grading enums and point values for the DDR play field.
package ddr_pkg;

  localparam logic [2:0] LANE_NONE = 3'b000;
  localparam logic [2:0] LANE_0    = 3'b001;
  localparam logic [2:0] LANE_1    = 3'b010;
  localparam logic [2:0] LANE_2    = 3'b011;
  localparam logic [2:0] LANE_3    = 3'b100;
  localparam logic [2:0] LANE_4    = 3'b101;

  localparam int unsigned PTS_PERFECT = 2;
  localparam int unsigned PTS_GOOD    = 1;

  typedef enum logic [1:0] {
    J_NONE,
    J_PERFECT,
    J_GOOD,
    J_MISS
  } judge_e;

  typedef enum logic {
    S_IDLE,
    S_ARMED
  } state_e;

  // True for the five real lanes; 000, 110 and 111 mean "no lane".
  function automatic logic lane_legal(input logic [2:0] code);
    return (code >= LANE_0) && (code <= LANE_4);
  endfunction

endpackage

// File: rtl/hit_judge_press_detect.sv
// press_detect: flags a new press whenever the encoder reports a legal lane
// different from the previous cycle's (illegal codes count as no lane).
module press_detect
  import ddr_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] lane_code,
  output logic       press,
  output logic [2:0] press_code
);

  logic [2:0] prev_code;
  logic [2:0] lane_eff;

  // Collapse illegal codes to LANE_NONE so 110/111 never look like a change.
  always_comb begin
    lane_eff   = lane_legal(lane_code) ? lane_code : LANE_NONE;
    press      = lane_legal(lane_code) && (lane_code != prev_code);
    press_code = lane_eff;
  end

  // Remember the last effective lane code every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_code <= LANE_NONE;
    end else begin
      prev_code <= lane_eff;
    end
  end

endmodule

// File: rtl/hit_judge.sv
// hit_judge: grades presses against one expected note at a time and keeps
// score / combo / max combo. Optional build macro HIT_JUDGE_STRAY_PENALTY_EN
// turns presses made while idle into misses.
module hit_judge
  import ddr_pkg::*;
#(
  parameter int unsigned WINDOW      = 16,
  parameter int unsigned PERFECT_WIN = 4,
  parameter int unsigned SCORE_W     = 16,
  parameter int unsigned COMBO_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         lane_code,
  input  logic               note_valid,
  input  logic [2:0]         note_code,
  output logic               note_ready,
  output logic               hit_perfect,
  output logic               hit_good,
  output logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic [COMBO_W-1:0] combo,
  output logic [COMBO_W-1:0] max_combo
);

  localparam int unsigned TW = (WINDOW > 2) ? $clog2(WINDOW) : 1;

  state_e       state_q, state_d;
  judge_e       judge_d;
  logic         accept;
  logic [2:0]   note_q;
  logic [TW-1:0] timer_q;
  logic         press;
  logic [2:0]   press_code;

  logic [SCORE_W:0]   score_sum;
  logic [COMBO_W:0]   combo_sum;
  logic [SCORE_W-1:0] score_nx;
  logic [COMBO_W-1:0] combo_nx;

  press_detect u_press (
    .clk        (clk),
    .rst_n      (rst_n),
    .lane_code  (lane_code),
    .press      (press),
    .press_code (press_code)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, note acceptance and the grade for this cycle.
  always_comb begin
    state_d    = state_q;
    judge_d    = J_NONE;
    accept     = 1'b0;
    note_ready = (state_q == S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (note_valid && lane_legal(note_code)) begin
          accept  = 1'b1;
          state_d = S_ARMED;
        end
`ifdef HIT_JUDGE_STRAY_PENALTY_EN
        // A press in the accepting cycle stays unjudged; only true strays cost.
        else if (press) begin
          judge_d = J_MISS;
        end
`endif
      end
      S_ARMED: begin
        if (press) begin
          state_d = S_IDLE;
          if (press_code == note_q) begin
            judge_d = (timer_q < TW'(PERFECT_WIN)) ? J_PERFECT : J_GOOD;
          end else begin
            judge_d = J_MISS;
          end
        end else if (timer_q == TW'(WINDOW - 1)) begin
          state_d = S_IDLE;
          judge_d = J_MISS;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Latch the expected note and run the window timer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      note_q  <= LANE_NONE;
      timer_q <= '0;
    end else if (accept) begin
      note_q  <= note_code;
      timer_q <= '0;
    end else if (state_q == S_ARMED) begin
      timer_q <= timer_q + 1'b1;
    end
  end

  // Saturating score / combo candidates for the current grade.
  always_comb begin
    score_sum = {1'b0, score};
    combo_sum = {1'b0, combo};
    unique case (judge_d)
      J_PERFECT: begin
        score_sum = {1'b0, score} + (SCORE_W + 1)'(PTS_PERFECT);
        combo_sum = {1'b0, combo} + 1'b1;
      end
      J_GOOD: begin
        score_sum = {1'b0, score} + (SCORE_W + 1)'(PTS_GOOD);
        combo_sum = {1'b0, combo} + 1'b1;
      end
      J_MISS:  combo_sum = '0;
      default: ;
    endcase
    score_nx = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    combo_nx = combo_sum[COMBO_W] ? '1 : combo_sum[COMBO_W-1:0];
  end

  // Pulses, score, combo and max combo all land on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_perfect <= 1'b0;
      hit_good    <= 1'b0;
      miss        <= 1'b0;
      score       <= '0;
      combo       <= '0;
      max_combo   <= '0;
    end else begin
      hit_perfect <= (judge_d == J_PERFECT);
      hit_good    <= (judge_d == J_GOOD);
      miss        <= (judge_d == J_MISS);
      score       <= score_nx;
      combo       <= combo_nx;
      if (combo_nx > max_combo) begin
        max_combo <= combo_nx;
      end
    end
  end

endmodule
